// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the bypassing register file and its lock scoreboard.
package regfile_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ADDR_BITS = 4;
    localparam int DEF_NUM_REGS  = 2 ** DEF_ADDR_BITS;

    // Lock vector at the default geometry; parametrised instances size their own.
    typedef logic [DEF_NUM_REGS-1:0] lock_vec_t;

    // True when addr is the hard-wired zero register and that feature is enabled.
    function automatic logic is_zero_reg(input logic [31:0] addr, input bit zero_reg);
        return zero_reg && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write locks; busy flags let a same-cycle writeback resolve the hazard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 lock_en_i,
    input  logic [ADDR_BITS-1:0] lock_addr_i,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [ADDR_BITS-1:0] rd_addr_a_i,
    input  logic [ADDR_BITS-1:0] rd_addr_b_i,
    output logic                 busy_a_o,
    output logic                 busy_b_o
);

    localparam int NUM_REGS = 2 ** ADDR_BITS;

    logic [NUM_REGS-1:0] lock_q;
    logic [NUM_REGS-1:0] lock_d;
    logic                wr_ok;
    logic                lock_ok;

    always_comb begin
        wr_ok   = wr_en_i   && !is_zero_reg(32'(wr_addr_i), ZERO_REG);
        lock_ok = lock_en_i && !is_zero_reg(32'(lock_addr_i), ZERO_REG);
    end

    // Set is applied after clear so a new pending write wins over the retiring one.
    always_comb begin
        lock_d = lock_q;
        if (wr_ok) begin
            lock_d[wr_addr_i] = 1'b0;
        end
        if (lock_ok) begin
            lock_d[lock_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end

    always_comb begin
        busy_a_o = lock_q[rd_addr_a_i] && !(wr_ok && (wr_addr_i == rd_addr_a_i));
        busy_b_o = lock_q[rd_addr_b_i] && !(wr_ok && (wr_addr_i == rd_addr_b_i));
    end

endmodule

// File: rtl/register_file_bypass.sv
// N x WIDTH register file: one write port, two registered read ports with write bypass.
module register_file_bypass
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr_a,
    input  logic [ADDR_BITS-1:0] rd_addr_b,
    output logic [WIDTH-1:0]     rd_data_a,
    output logic [WIDTH-1:0]     rd_data_b,
    output logic                 rd_valid,
    input  logic                 lock_en,
    input  logic [ADDR_BITS-1:0] lock_addr,
    output logic                 busy_a,
    output logic                 busy_b
);

    localparam int NUM_REGS = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] rd_data_a_q;
    logic [WIDTH-1:0] rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q;
    logic [WIDTH-1:0] rd_data_b_d;
    logic             rd_valid_q;
    logic             wr_ok;

    always_comb begin
        wr_ok = wr_en && !is_zero_reg(32'(wr_addr), ZERO_REG);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Zero register takes priority over the bypass path.
    always_comb begin
        if (is_zero_reg(32'(rd_addr_a), ZERO_REG)) begin
            rd_data_a_d = '0;
        end else if (wr_ok && (wr_addr == rd_addr_a)) begin
            rd_data_a_d = wr_data;
        end else begin
            rd_data_a_d = regs_q[rd_addr_a];
        end

        if (is_zero_reg(32'(rd_addr_b), ZERO_REG)) begin
            rd_data_b_d = '0;
        end else if (wr_ok && (wr_addr == rd_addr_b)) begin
            rd_data_b_d = wr_data;
        end else begin
            rd_data_b_d = regs_q[rd_addr_b];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_a_q <= rd_data_a_d;
                rd_data_b_q <= rd_data_b_d;
            end
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_valid  = rd_valid_q;

    regfile_scoreboard #(
        .ADDR_BITS (ADDR_BITS),
        .ZERO_REG  (ZERO_REG)
    ) u_scoreboard (
        .clock_i     (clock),
        .reset_ni    (reset),
        .lock_en_i   (lock_en),
        .lock_addr_i (lock_addr),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .rd_addr_a_i (rd_addr_a),
        .rd_addr_b_i (rd_addr_b),
        .busy_a_o    (busy_a),
        .busy_b_o    (busy_b)
    );

endmodule

// File: tb/tb_register_file_bypass.sv
// Directed bench: default 32x16 instance with zero register, plus a 16x8 instance without.
module tb_register_file_bypass;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    // Default instance: WIDTH=32, ADDR_BITS=4, ZERO_REG=1
    logic        a_wr_en = 1'b0;
    logic [3:0]  a_wr_addr = '0;
    logic [31:0] a_wr_data = '0;
    logic        a_rd_en = 1'b0;
    logic [3:0]  a_rd_addr_a = '0;
    logic [3:0]  a_rd_addr_b = '0;
    logic [31:0] a_rd_data_a;
    logic [31:0] a_rd_data_b;
    logic        a_rd_valid;
    logic        a_lock_en = 1'b0;
    logic [3:0]  a_lock_addr = '0;
    logic        a_busy_a;
    logic        a_busy_b;

    // Sweep instance: WIDTH=16, ADDR_BITS=3, ZERO_REG=0
    logic        s_wr_en = 1'b0;
    logic [2:0]  s_wr_addr = '0;
    logic [15:0] s_wr_data = '0;
    logic        s_rd_en = 1'b0;
    logic [2:0]  s_rd_addr_a = '0;
    logic [2:0]  s_rd_addr_b = '0;
    logic [15:0] s_rd_data_a;
    logic [15:0] s_rd_data_b;
    logic        s_rd_valid;
    logic        s_lock_en = 1'b0;
    logic [2:0]  s_lock_addr = '0;
    logic        s_busy_a;
    logic        s_busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_bypass #(.WIDTH(32), .ADDR_BITS(4), .ZERO_REG(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (a_wr_en),
        .wr_addr   (a_wr_addr),
        .wr_data   (a_wr_data),
        .rd_en     (a_rd_en),
        .rd_addr_a (a_rd_addr_a),
        .rd_addr_b (a_rd_addr_b),
        .rd_data_a (a_rd_data_a),
        .rd_data_b (a_rd_data_b),
        .rd_valid  (a_rd_valid),
        .lock_en   (a_lock_en),
        .lock_addr (a_lock_addr),
        .busy_a    (a_busy_a),
        .busy_b    (a_busy_b)
    );

    register_file_bypass #(.WIDTH(16), .ADDR_BITS(3), .ZERO_REG(1'b0)) dut_sweep (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (s_wr_en),
        .wr_addr   (s_wr_addr),
        .wr_data   (s_wr_data),
        .rd_en     (s_rd_en),
        .rd_addr_a (s_rd_addr_a),
        .rd_addr_b (s_rd_addr_b),
        .rd_data_a (s_rd_data_a),
        .rd_data_b (s_rd_data_b),
        .rd_valid  (s_rd_valid),
        .lock_en   (s_lock_en),
        .lock_addr (s_lock_addr),
        .busy_a    (s_busy_a),
        .busy_b    (s_busy_b)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach summary, got timeout, required finish");
        $fatal(1);
    end

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        a_wr_en   = 1'b0;
        a_rd_en   = 1'b0;
        a_lock_en = 1'b0;
        s_wr_en   = 1'b0;
        s_rd_en   = 1'b0;
        s_lock_en = 1'b0;
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [31:0] data);
        a_wr_en   = 1'b1;
        a_wr_addr = addr;
        a_wr_data = data;
    endtask

    task automatic a_read(input logic [3:0] ra, input logic [3:0] rb);
        a_rd_en     = 1'b1;
        a_rd_addr_a = ra;
        a_rd_addr_b = rb;
    endtask

    initial begin
        logic [15:0] exp_a;
        logic [15:0] exp_b;

        // Reset state
        #3;
        check("rst_rd_a", a_rd_data_a, 32'h0);
        check("rst_rd_b", a_rd_data_b, 32'h0);
        check("rst_valid", 32'(a_rd_valid), 32'd0);
        check("rst_sweep_valid", 32'(s_rd_valid), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Mid-run reset discards written data and locks
        a_write(4'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        a_read(4'd5, 4'd5);
        a_lock_en   = 1'b1;
        a_lock_addr = 4'd4;
        tick();
        idle();
        check("pre_rst_rd_a", a_rd_data_a, 32'hDEAD_BEEF);
        check("pre_rst_valid", 32'(a_rd_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_rd_a", a_rd_data_a, 32'h0);
        check("async_rst_rd_b", a_rd_data_b, 32'h0);
        check("async_rst_valid", 32'(a_rd_valid), 32'd0);
        tick();
        reset = 1'b1;
        a_read(4'd5, 4'd5);
        tick();
        idle();
        check("post_rst_reg5_a", a_rd_data_a, 32'h0);
        check("post_rst_reg5_b", a_rd_data_b, 32'h0);
        check("post_rst_valid", 32'(a_rd_valid), 32'd1);
        for (int i = 0; i < 16; i++) begin
            a_rd_addr_a = 4'(i);
            a_rd_addr_b = 4'(15 - i);
            #1;
            check($sformatf("post_rst_busy_a_%0d", i), 32'(a_busy_a), 32'd0);
            check($sformatf("post_rst_busy_b_%0d", i), 32'(a_busy_b), 32'd0);
        end
        tick();

        // Write then read, one-cycle valid pulse, hold with rd_en=0
        a_write(4'd3, 32'h1234_5678);
        tick();
        idle();
        a_read(4'd3, 4'd3);
        tick();
        idle();
        check("wr_rd_a", a_rd_data_a, 32'h1234_5678);
        check("wr_rd_b", a_rd_data_b, 32'h1234_5678);
        check("wr_rd_valid", 32'(a_rd_valid), 32'd1);
        tick();
        check("valid_pulse_end", 32'(a_rd_valid), 32'd0);
        check("hold_a", a_rd_data_a, 32'h1234_5678);

        // Bypass on port A, stored data on port B
        a_write(4'd2, 32'h0000_0011);
        tick();
        idle();
        a_write(4'd7, 32'hA5A5_A5A5);
        a_read(4'd7, 4'd2);
        tick();
        idle();
        check("bypass_a", a_rd_data_a, 32'hA5A5_A5A5);
        check("bypass_b", a_rd_data_b, 32'h0000_0011);

        // Zero register: ignored write, even when bypassing
        a_write(4'd0, 32'hFFFF_FFFF);
        a_read(4'd0, 4'd7);
        tick();
        idle();
        check("zero_bypass_a", a_rd_data_a, 32'h0);
        check("zero_bypass_b", a_rd_data_b, 32'hA5A5_A5A5);
        a_read(4'd0, 4'd0);
        tick();
        idle();
        check("zero_later_a", a_rd_data_a, 32'h0);
        a_lock_en   = 1'b1;
        a_lock_addr = 4'd0;
        tick();
        idle();
        a_rd_addr_a = 4'd0;
        #1;
        check("zero_lock_busy", 32'(a_busy_a), 32'd0);

        // Scoreboard set, same-cycle resolve, clear, lock-wins
        a_lock_en   = 1'b1;
        a_lock_addr = 4'd9;
        tick();
        idle();
        a_rd_addr_a = 4'd9;
        a_rd_addr_b = 4'd9;
        #1;
        check("lock9_busy_a", 32'(a_busy_a), 32'd1);
        check("lock9_busy_b", 32'(a_busy_b), 32'd1);
        a_write(4'd9, 32'hCAFE_0009);
        #1;
        check("wb_resolve_busy_a", 32'(a_busy_a), 32'd0);
        check("wb_resolve_busy_b", 32'(a_busy_b), 32'd0);
        tick();
        idle();
        #1;
        check("lock9_cleared", 32'(a_busy_a), 32'd0);
        a_write(4'd9, 32'hBEEF_0009);
        a_lock_en   = 1'b1;
        a_lock_addr = 4'd9;
        tick();
        idle();
        #1;
        check("lock_wins_busy_a", 32'(a_busy_a), 32'd1);
        a_read(4'd9, 4'd3);
        tick();
        idle();
        check("reg9_data", a_rd_data_a, 32'hBEEF_0009);
        check("reg3_still", a_rd_data_b, 32'h1234_5678);

        // Parameter sweep: all 8 registers, reg0 ordinary
        for (int i = 0; i < 8; i++) begin
            s_wr_en   = 1'b1;
            s_wr_addr = 3'(i);
            s_wr_data = 16'((i + 1) * 16'h1111);
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            s_rd_en     = 1'b1;
            s_rd_addr_a = 3'(i);
            s_rd_addr_b = 3'(7 - i);
            exp_a = 16'((i + 1) * 16'h1111);
            exp_b = 16'((8 - i) * 16'h1111);
            tick();
            check($sformatf("sweep_rd_a_%0d", i), 32'(s_rd_data_a), 32'(exp_a));
            check($sformatf("sweep_rd_b_%0d", i), 32'(s_rd_data_b), 32'(exp_b));
        end
        idle();
        s_wr_en     = 1'b1;
        s_wr_addr   = 3'd0;
        s_wr_data   = 16'hBEEF;
        s_rd_en     = 1'b1;
        s_rd_addr_a = 3'd0;
        s_rd_addr_b = 3'd7;
        s_lock_en   = 1'b1;
        s_lock_addr = 3'd7;
        tick();
        idle();
        check("sweep_reg0_bypass", 32'(s_rd_data_a), 32'h0000_BEEF);
        check("sweep_reg7", 32'(s_rd_data_b), 32'h0000_8888);
        s_lock_en   = 1'b1;
        s_lock_addr = 3'd0;
        tick();
        idle();
        s_rd_addr_a = 3'd0;
        s_rd_addr_b = 3'd7;
        #1;
        check("sweep_lock0_busy", 32'(s_busy_a), 32'd1);
        check("sweep_lock7_busy", 32'(s_busy_b), 32'd1);
        s_rd_addr_a = 3'd1;
        #1;
        check("sweep_reg1_not_busy", 32'(s_busy_a), 32'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_bypass.md
Name: register_file_bypass

Overview:
- Parametrised successor of the processor register bank: N x WIDTH registers, one write port, two read ports.
- Clocked synchronous write; registered reads with read-valid strobe; write-to-read bypass.
- Optional hard-wired zero register.
- Per-register pending-write lock (scoreboard) so the control unit can detect RAW hazards before issuing.
- Sits between instruction decode/control and the ALU / writeback stage.

Parameters:
- WIDTH, 32, bits per register word
- ADDR_BITS, 4, address width; NUM_REGS = 2**ADDR_BITS (derived localparam, not overridable)
- ZERO_REG, 1, 1: register 0 always reads 0, and writes/locks to it are ignored; 0: register 0 is ordinary

Ports:
- clock  in  1  single system clock, rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_BITS  write address
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request for both ports
- rd_addr_a  in  ADDR_BITS  read address A
- rd_addr_b  in  ADDR_BITS  read address B
- rd_data_a  out  WIDTH  registered read data A
- rd_data_b  out  WIDTH  registered read data B
- rd_valid  out  1  one-cycle pulse: rd_data_a/b updated this cycle
- lock_en  in  1  mark lock_addr as pending a future write
- lock_addr  in  ADDR_BITS  register to lock
- busy_a  out  1  combinational: rd_addr_a is locked
- busy_b  out  1  combinational: rd_addr_b is locked

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, rd_data_a/b = 0, rd_valid = 0, all lock bits = 0. Reset asserted mid-operation discards any in-flight write or read; no output glitches to stale data afterwards.
- Write: on rising clock with wr_en=1, reg[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is ignored.
- Read: on rising clock with rd_en=1, rd_data_a <= value(rd_addr_a), rd_data_b <= value(rd_addr_b), rd_valid <= 1. Latency is 1 cycle. With rd_en=0: rd_valid <= 0 and rd_data_a/b hold.
- Bypass: if wr_en=1 and wr_addr equals a read address in the same cycle (and the write is not ignored), that port captures wr_data, not the old contents.
- Zero register: with ZERO_REG=1, address 0 always reads 0, even when bypassing.
- Both read ports may address the same register. Reads and writes in the same cycle are always legal.
- Lock set: on rising clock with lock_en=1, lock[lock_addr] <= 1 (ignored for addr 0 when ZERO_REG=1).
- Lock clear: a performed write to address X clears lock[X].
- Simultaneous lock_en and wr_en to the same address: the lock wins (bit ends at 1). This models a new pending write issued as the old one retires.
- busy_a = lock[rd_addr_a] AND NOT (wr_en AND wr_addr==rd_addr_a AND write not ignored). busy_b is the same for rd_addr_b. This lets a same-cycle writeback resolve the hazard.
- rd_en is not gated by busy. Stalling on busy is the control unit's responsibility.
- No FSM. State is the register array, the lock vector, and the output registers.

Decomposition:
- Shared package regfile_pkg:
  - ADDR_BITS/WIDTH defaults
  - function is_zero_reg(addr, ZERO_REG)
  - typedef for the lock vector [NUM_REGS-1:0]
- One natural sub-module: regfile_scoreboard. It holds the lock vector and set/clear/busy logic, parametrised by ADDR_BITS and ZERO_REG. The data array and bypass stay in the top module.

Test Plan:
- Reset: drive reset=0 mid-run after writing reg5=0xDEADBEEF -> rd_data_a/b=0, rd_valid=0 immediately. After release, reading 5 returns 0 and busy for all addresses is 0.
- Write/read: write reg3=0x12345678, next cycle rd_en with a=3, b=3 -> one cycle later rd_data_a=rd_data_b=0x12345678, rd_valid=1 for exactly one cycle.
- Bypass: same cycle wr_en reg7=0xA5A5A5A5 and rd_en a=7, b=2 (reg2=0x11) -> rd_data_a=0xA5A5A5A5, rd_data_b=0x11.
- Zero reg (ZERO_REG=1): write reg0=0xFFFFFFFF with simultaneous read a=0, then later read a=0 -> 0 both times. lock_en addr 0 -> busy_a stays 0.
- Scoreboard: lock_en addr 9; next cycle rd_addr_a=9 -> busy_a=1. In a cycle with wr_en addr 9, busy_a=0 combinationally and the lock clears after the edge. lock_en and wr_en addr 9 in the same cycle -> busy_a=1 afterwards.
- Parameter sweep: WIDTH=16, ADDR_BITS=3, ZERO_REG=0 -> write/read all 8 registers with distinct patterns. Reg0 is writable, and addresses wrap only within 0..7.
